instr_issue_queue: RTL and testbench

INSTR_ISSUE_QUEUE -- requirements
Module: instr_issue_queue

---
 rtl/instr_issue_queue.sv | 125 ++++++++++++
 tb/tb_instr_issue_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_queue.sv
// rtl/instr_issue_queue.sv - in-order ALU issue queue with result-broadcast snooping
module instr_issue_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [2:0]               enq_funct3,
  input  logic                     enq_funct7,
  input  logic                     enq_imm,
  input  logic [4:0]               enq_destination,
  input  logic [4:0]               enq_r1,
  input  logic [4:0]               enq_r2,
  input  logic [31:0]              enq_src1,
  input  logic [31:0]              enq_src2,
  input  logic [36:0]              cmd_buf_alu,
  input  logic [36:0]              cmd_buf_ld_str,
  input  logic [36:0]              cmd_buf_mul,
  input  logic [36:0]              cmd_buf_div,
  input  logic                     rs_free,
  output logic                     iq_assert,
  output logic [2:0]               funct3,
  output logic                     funct7,
  output logic                     imm,
  output logic [4:0]               destination,
  output logic [4:0]               r1,
  output logic [4:0]               r2,
  output logic [31:0]              src1,
  output logic [31:0]              src2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [2:0]  funct3;
    logic        funct7;
    logic        imm;
    logic [4:0]  destination;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] src1;
    logic [31:0] src2;
  } entry_t;

  // Broadcasts ordered lowest priority first, so a later match overrides an earlier one.
  logic [3:0][36:0] bcast;
  assign bcast = {cmd_buf_div, cmd_buf_mul, cmd_buf_ld_str, cmd_buf_alu};

  // Resolve one pending tag against all broadcasts; returns {tag, value}.
  function automatic logic [36:0] resolve(logic [4:0] tag, logic [31:0] val,
                                          logic [3:0][36:0] bc);
    logic [36:0] res;
    res = {tag, val};
    for (int i = 0; i < 4; i++) begin
      if (tag != 5'd0 && bc[i][36:32] == tag) res = {5'd0, bc[i][31:0]};
    end
    return res;
  endfunction

  function automatic entry_t snoop(entry_t e, logic [3:0][36:0] bc);
    entry_t o;
    o = e;
    {o.r1, o.src1} = resolve(e.r1, e.src1, bc);
    {o.r2, o.src2} = resolve(e.r2, e.src2, bc);
    return o;
  endfunction

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  entry_t          enq_entry;
  entry_t          head_entry;
  entry_t          out_entry;
  logic            do_enq;

  assign enq_entry  = snoop('{funct3: enq_funct3, funct7: enq_funct7, imm: enq_imm,
                              destination: enq_destination, r1: enq_r1, r2: enq_r2,
                              src1: enq_src1, src2: enq_src2}, bcast);
  assign head_entry = snoop(mem[head], bcast);
  assign out_entry  = (count != '0) ? head_entry : '0;

  assign enq_ready  = (count < CW'(DEPTH));
  assign do_enq     = enq_valid && enq_ready && !flush;
  assign iq_assert  = reset && (count != '0) && rs_free && !flush;

  assign {funct3, funct7, imm, destination, r1, r2, src1, src2} = out_entry;

  // Pointer/occupancy update, per-entry snooping and enqueue write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= snoop(mem[i], bcast);
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_enq) begin
          mem[tail] <= enq_entry;
          tail      <= tail + 1'b1;
        end
        if (iq_assert) head <= head + 1'b1;
        case ({do_enq, iq_assert})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Occupancy must stay within the queue size.
  always_ff @(posedge clk) begin
    if (reset) assert (count <= CW'(DEPTH));
  end

endmodule

// File: tb/tb_instr_issue_queue.sv
// tb/tb_instr_issue_queue.sv - self-checking bench for instr_issue_queue
module tb_instr_issue_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, enq_valid, rs_free;
  logic [2:0]  enq_funct3;
  logic        enq_funct7, enq_imm;
  logic [4:0]  enq_destination, enq_r1, enq_r2;
  logic [31:0] enq_src1, enq_src2;
  logic [36:0] cb_alu, cb_ld, cb_mul, cb_div;
  logic        enq_ready, iq_assert;
  logic [2:0]  funct3;
  logic        funct7, imm;
  logic [4:0]  destination, r1, r2;
  logic [31:0] src1, src2;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  instr_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_funct3(enq_funct3), .enq_funct7(enq_funct7), .enq_imm(enq_imm),
    .enq_destination(enq_destination), .enq_r1(enq_r1), .enq_r2(enq_r2),
    .enq_src1(enq_src1), .enq_src2(enq_src2),
    .cmd_buf_alu(cb_alu), .cmd_buf_ld_str(cb_ld), .cmd_buf_mul(cb_mul), .cmd_buf_div(cb_div),
    .rs_free(rs_free), .iq_assert(iq_assert),
    .funct3(funct3), .funct7(funct7), .imm(imm), .destination(destination),
    .r1(r1), .r2(r2), .src1(src1), .src2(src2), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  f3;
    logic        f7;
    logic        im;
    logic [4:0]  dst;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] s1;
    logic [31:0] s2;
  } ent_t;

  typedef struct {
    logic       rst_n;
    logic       fl;
    logic       ev;
    logic [4:0] dst;
    logic       rs;
    logic       exp_ready;
    logic       exp_iq;
    logic [4:0] exp_dst;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vt[$];
  ent_t mq[$];

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    reset = 1'b1; flush = 1'b0; enq_valid = 1'b0; rs_free = 1'b0;
    enq_funct3 = '0; enq_funct7 = 1'b0; enq_imm = 1'b0; enq_destination = '0;
    enq_r1 = '0; enq_r2 = '0; enq_src1 = '0; enq_src2 = '0;
    cb_alu = '0; cb_ld = '0; cb_mul = '0; cb_div = '0;
  endtask

  function automatic void v(logic rst_n, logic fl, logic ev, logic [4:0] dst, logic rs,
                            logic rdy, logic iq, logic [4:0] odst, logic [2:0] cnt);
    vec_t r;
    r.rst_n = rst_n; r.fl = fl; r.ev = ev; r.dst = dst; r.rs = rs;
    r.exp_ready = rdy; r.exp_iq = iq; r.exp_dst = odst; r.exp_cnt = cnt;
    vt.push_back(r);
  endfunction

  // Reference snoop: scan broadcasts from highest priority down, first hit wins.
  function automatic ent_t snoop_e(ent_t e);
    logic [36:0] pri [4];
    ent_t o;
    pri[0] = cb_div; pri[1] = cb_mul; pri[2] = cb_ld; pri[3] = cb_alu;
    o = e;
    if (e.r1 != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (pri[i][36:32] == e.r1) begin o.r1 = 0; o.s1 = pri[i][31:0]; break; end
      end
    end
    if (e.r2 != 0) begin
      for (int i = 0; i < 4; i++) begin
        if (pri[i][36:32] == e.r2) begin o.r2 = 0; o.s2 = pri[i][31:0]; break; end
      end
    end
    return o;
  endfunction

  function automatic logic [36:0] rand_bcast();
    logic [36:0] b;
    b = '0;
    if ($urandom_range(0, 1) == 1) b = {5'($urandom_range(0, 7)), 32'($urandom)};
    return b;
  endfunction

  initial begin
    ent_t e, exp_out;
    logic exp_iq;
    int rs_bias;

    set_idle();
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;

    // Fill to full, then drain
    v(1,0,0,0,0, 1,0,0,0);
    v(1,0,1,1,0, 1,0,0,0);
    v(1,0,1,2,0, 1,0,1,1);
    v(1,0,1,3,0, 1,0,1,2);
    v(1,0,1,4,0, 1,0,1,3);
    v(1,0,1,5,0, 0,0,1,4);
    v(1,0,0,0,0, 0,0,1,4);
    v(1,0,0,0,1, 0,1,1,4);
    v(1,0,0,0,1, 1,1,2,3);
    v(1,0,0,0,1, 1,1,3,2);
    v(1,0,0,0,1, 1,1,4,1);
    v(1,0,0,0,1, 1,0,0,0);
    // In-order issue of 1,2,3
    v(1,0,1,1,0, 1,0,0,0);
    v(1,0,1,2,0, 1,0,1,1);
    v(1,0,1,3,0, 1,0,1,2);
    v(1,0,0,0,1, 1,1,1,3);
    v(1,0,0,0,1, 1,1,2,2);
    v(1,0,0,0,1, 1,1,3,1);
    v(1,0,0,0,1, 1,0,0,0);
    // Flush mid-stream with enqueue and issue requested
    v(1,0,1,1,0, 1,0,0,0);
    v(1,0,1,2,0, 1,0,1,1);
    v(1,0,1,3,0, 1,0,1,2);
    v(1,1,1,9,1, 1,0,1,3);
    v(1,0,0,0,1, 1,0,0,0);
    // Reset mid-stream with enqueue and issue requested
    v(1,0,1,1,0, 1,0,0,0);
    v(1,0,1,2,0, 1,0,1,1);
    v(1,0,1,3,0, 1,0,1,2);
    v(0,0,1,9,1, 1,0,1,3);
    v(1,0,0,0,1, 1,0,0,0);
    // Simultaneous enqueue and issue keeps count
    v(1,0,1,1,0, 1,0,0,0);
    v(1,0,1,2,1, 1,1,1,1);
    v(1,0,0,0,1, 1,1,2,1);
    v(1,0,0,0,0, 1,0,0,0);

    for (int i = 0; i < vt.size(); i++) begin
      set_idle();
      reset = vt[i].rst_n; flush = vt[i].fl; enq_valid = vt[i].ev;
      enq_destination = vt[i].dst; rs_free = vt[i].rs;
      #2;
      chk($sformatf("vec%0d.enq_ready", i), 96'(enq_ready), 96'(vt[i].exp_ready));
      chk($sformatf("vec%0d.iq_assert", i), 96'(iq_assert), 96'(vt[i].exp_iq));
      chk($sformatf("vec%0d.destination", i), 96'(destination), 96'(vt[i].exp_dst));
      chk($sformatf("vec%0d.count", i), 96'(count), 96'(vt[i].exp_cnt));
      tick();
    end

    // Snoop while queued: mul broadcast resolves stored r1
    set_idle();
    enq_valid = 1'b1; enq_r1 = 5'd7; enq_destination = 5'd11;
    tick();
    set_idle();
    #2;
    chk("queued.r1_pending", 96'(r1), 96'(7));
    cb_mul = {5'd7, 32'hDEAD_BEEF};
    tick();
    set_idle();
    rs_free = 1'b1;
    #2;
    chk("queued.iq_assert", 96'(iq_assert), 96'(1));
    chk("queued.r1", 96'(r1), 96'(0));
    chk("queued.src1", 96'(src1), 96'(32'hDEAD_BEEF));
    tick();

    // Same-cycle bypass at enqueue and at issue
    set_idle();
    enq_valid = 1'b1; enq_r1 = 5'd3; enq_r2 = 5'd5; enq_destination = 5'd12;
    cb_alu = {5'd5, 32'h10};
    tick();
    set_idle();
    #2;
    chk("bypass_enq.r2", 96'(r2), 96'(0));
    chk("bypass_enq.src2", 96'(src2), 96'(32'h10));
    chk("bypass_enq.r1_pending", 96'(r1), 96'(3));
    cb_div = {5'd3, 32'h20};
    rs_free = 1'b1;
    #2;
    chk("bypass_iss.iq_assert", 96'(iq_assert), 96'(1));
    chk("bypass_iss.r1", 96'(r1), 96'(0));
    chk("bypass_iss.src1", 96'(src1), 96'(32'h20));
    tick();
    set_idle();
    #2;
    chk("bypass_iss.count", 96'(count), 96'(0));
    chk("empty.payload_zero", 96'({funct3, funct7, imm, destination, r1, r2, src1, src2}), 96'(0));

    // Priority among simultaneous matching broadcasts
    set_idle();
    enq_valid = 1'b1; enq_r1 = 5'd9; enq_r2 = 5'd4; enq_destination = 5'd13;
    tick();
    set_idle();
    cb_alu = {5'd9, 32'd1}; cb_div = {5'd9, 32'd2};
    cb_ld  = {5'd4, 32'd3}; cb_mul = {5'd4, 32'd5};
    tick();
    set_idle();
    #2;
    chk("prio.r1", 96'(r1), 96'(0));
    chk("prio.src1", 96'(src1), 96'(2));
    chk("prio.src2", 96'(src2), 96'(5));
    rs_free = 1'b1;
    tick();

    // reg_id 0 must not disturb a valid operand
    set_idle();
    enq_valid = 1'b1; enq_src1 = 32'hAA; cb_div = {5'd0, 32'h55};
    tick();
    set_idle();
    cb_alu = {5'd0, 32'h66};
    #2;
    chk("regid0.src1", 96'(src1), 96'(32'hAA));
    rs_free = 1'b1;
    tick();

    // Randomized run against the queue model
    set_idle();
    reset = 1'b0;
    tick();
    mq.delete();
    rs_bias = 50;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc % 200 == 0) rs_bias = (cyc / 200 % 3 == 0) ? 15 : ((cyc / 200 % 3 == 1) ? 50 : 90);
      reset           = ($urandom_range(0, 59) != 0);
      flush           = ($urandom_range(0, 24) == 0);
      enq_valid       = ($urandom_range(0, 99) < 60);
      rs_free         = ($urandom_range(0, 99) < rs_bias);
      enq_funct3      = 3'($urandom);
      enq_funct7      = 1'($urandom);
      enq_imm         = 1'($urandom);
      enq_destination = 5'($urandom);
      enq_r1          = 5'($urandom_range(0, 7));
      enq_r2          = 5'($urandom_range(0, 7));
      enq_src1        = $urandom;
      enq_src2        = $urandom;
      cb_alu = rand_bcast(); cb_ld = rand_bcast(); cb_mul = rand_bcast(); cb_div = rand_bcast();
      #2;
      exp_iq  = reset && (mq.size() != 0) && rs_free && !flush;
      exp_out = (mq.size() != 0) ? snoop_e(mq[0]) : '0;
      chk("rnd.count", 96'(count), 96'(mq.size()));
      chk("rnd.enq_ready", 96'(enq_ready), 96'(mq.size() < DEPTH));
      chk("rnd.iq_assert", 96'(iq_assert), 96'(exp_iq));
      chk("rnd.payload", 96'({funct3, funct7, imm, destination, r1, r2, src1, src2}), 96'(exp_out));
      if (!reset || flush) begin
        mq.delete();
      end else begin
        e = '{f3: enq_funct3, f7: enq_funct7, im: enq_imm, dst: enq_destination,
              r1: enq_r1, r2: enq_r2, s1: enq_src1, s2: enq_src2};
        if (enq_valid && mq.size() < DEPTH) begin
          if (exp_iq) void'(mq.pop_front());
          foreach (mq[k]) mq[k] = snoop_e(mq[k]);
          mq.push_back(snoop_e(e));
        end else begin
          if (exp_iq) void'(mq.pop_front());
          foreach (mq[k]) mq[k] = snoop_e(mq[k]);
        end
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
